instruction_fetch: RTL and testbench

Fetch stage directly upstream of the RV32I instruction decoder. It holds the PC, issues word reads to instruction memory over a req/ack handshake, and registers the returned word. It presents the word to decode with a valid/ready handshake and applies redirects from branch/jump resolution. Latency-tolerant: memory may ack in the same cycle or any number of cycles later.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_pc_next.sv | 42 ++++
 rtl/instruction_fetch.sv | 139 +++++++++++++
 tb/tb_instruction_fetch.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t    : fetch engine states (FAULT only reachable when
//                      IFETCH_MISALIGN_CHECK_EN is defined)
//   NOP_INSN         : canonical RV32I NOP (addi x0, x0, 0)
//   DEFAULT_RESET_PC : default PC loaded on reset
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at pc
        HOLD  = 2'd1,   // instruction presented to decode
        DRAIN = 2'd2,   // waiting out a request abandoned by a redirect
        FAULT = 2'd3    // misaligned redirect target presented as a fault
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;

endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: combinational next-PC select for the fetch stage.
// Priority: reset > redirect > advance (pc+4, wraps) > hold.
// Macro IFETCH_MISALIGN_CHECK_EN: when defined the redirect target is taken
// verbatim so the caller can detect a misaligned target; when undefined the
// target's low two bits are forced to zero.
// Ports:
//   reset, reset_pc            : synchronous reset request and its PC
//   pc                         : current PC
//   redirect_valid/redirect_pc : branch/jump redirect
//   advance                    : instruction accepted by decode
//   pc_next                    : PC for the next cycle
module fetch_pc_next #(
    parameter int ADDR_W = 32
) (
    input  logic              reset,
    input  logic [ADDR_W-1:0] reset_pc,
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] target;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign target = redirect_pc;
`else
    assign target = redirect_pc & ~ADDR_W'(3);
`endif

    always_comb begin
        pc_next = pc;
        if (reset)
            pc_next = reset_pc;
        else if (redirect_valid)
            pc_next = target;
        else if (advance)
            pc_next = pc + ADDR_W'(4);
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage feeding the decoder.
// Holds the PC, reads one word at a time from instruction memory over a
// req/ack handshake, registers the word and offers it to decode with a
// valid/ready handshake. Redirects win over every other event in a cycle.
// Macro IFETCH_MISALIGN_CHECK_EN enables the misaligned-target FAULT state;
// without it fetch_fault is tied low and redirect targets are word-aligned.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mem_req/mem_addr           : word read request (address held until ack)
//   mem_ack/mem_rdata          : request accepted, data valid same cycle
//   inst_valid/inst_ready      : handshake toward decode
//   instruction/inst_pc/inst_pc_plus4 : fetched word, its address, link value
//   redirect_valid/redirect_pc : new PC from branch/jump resolution
//   fetch_fault                : misaligned redirect target presented
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc_plus4,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_fault
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] drain_addr;   // address of the abandoned request
    logic              fire;
    logic              capture;
    logic              latch_drain;
    fetch_state_t      resume_state; // where to go once no request is pending

    assign fire = (state == HOLD) && inst_ready && !redirect_valid;

    fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .reset          (reset),
        .reset_pc       (RESET_PC),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (fire),
        .pc_next        (pc_next)
    );

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign resume_state = (pc_next[1:0] != 2'b00) ? FAULT : FETCH;
`else
    assign resume_state = FETCH;
`endif

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        latch_drain = 1'b0;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    if (mem_ack) begin
                        state_next = resume_state;  // returned word discarded
                    end else begin
                        state_next  = DRAIN;
                        latch_drain = 1'b1;
                    end
                end else if (mem_ack) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid)
                    state_next = resume_state;      // held word dropped
                else if (inst_ready)
                    state_next = FETCH;
            end
            DRAIN: begin
                // pc_next already reflects any redirect seen in DRAIN
                if (mem_ack)
                    state_next = resume_state;
            end
`ifdef IFETCH_MISALIGN_CHECK_EN
            FAULT: begin
                if (redirect_valid)
                    state_next = resume_state;
            end
`endif
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        pc <= pc_next;
        if (reset) begin
            state       <= FETCH;
            instruction <= NOP_INSN;
            inst_pc     <= RESET_PC;
            drain_addr  <= RESET_PC;
        end else begin
            state <= state_next;
            if (latch_drain)
                drain_addr <= pc;
            if (capture) begin
                instruction <= mem_rdata;
                inst_pc     <= pc;
            end
`ifdef IFETCH_MISALIGN_CHECK_EN
            else if (state_next == FAULT) begin
                instruction <= NOP_INSN;
                inst_pc     <= pc_next;
            end
`endif
        end
    end

    // Request is dropped combinationally in the reset cycle.
    assign mem_req       = !reset && ((state == FETCH) || (state == DRAIN));
    assign mem_addr      = ((state == DRAIN) ? drain_addr : pc) & ~ADDR_W'(3);
    assign inst_pc_plus4 = inst_pc + ADDR_W'(4);

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign inst_valid  = (state == HOLD) || (state == FAULT);
    assign fetch_fault = (state == FAULT);
`else
    assign inst_valid  = (state == HOLD);
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. A memory model answers requests
// with programmable or random latency; a scoreboard queue holds the PC decode
// is architecturally expected to receive next, and a monitor checks every
// accepted instruction against it plus memory-protocol invariants.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_fault;

    instruction_fetch #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          accepts = 0;
    logic [31:0] expq[$];
    int          lat_force = 0;   // <0 means random latency 0..3

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0050_0093;
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Driver-side scoreboard update: decode must next see the redirect target.
    task automatic do_redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        expq.delete();
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (t[1:0] == 2'b00) expq.push_back(t);
`else
        expq.push_back(t & ~32'd3);
`endif
    endtask

    task automatic wait_valid(input string name, input int max);
        int n = 0;
        while (!inst_valid && n < max) begin
            @(negedge clk); #3;
            n++;
        end
        if (!inst_valid) begin
            checks++; failures++;
            $display("FAIL %s: inst_valid not seen within %0d cycles", name, max);
        end
    endtask

    task automatic accept_one();
        @(negedge clk); inst_ready = 1'b1; #3;
        @(negedge clk); inst_ready = 1'b0;
    endtask

    // Memory model: answers at negedge+1 so ack/data are settled for the edge.
    initial begin : memory
        int   lat = 0;
        int   cnt = 0;
        logic prev_ack = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (prev_ack || !mem_req) begin
                cnt = 0;
                lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
            end
            if (mem_req && cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                if (mem_req) cnt++;
            end
            prev_ack = mem_ack;
        end
    end

    // Monitor: sees the exact values the DUT samples at the next rising edge.
    initial begin : monitor
        logic        prev_wait = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        logic [31:0] e;
        forever begin
            @(negedge clk); #2;
            if (reset) begin
                prev_wait = 1'b0;
            end else begin
                if (mem_req) chk("mem_addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
                if (prev_wait) begin
                    chk("mem_req_held", {31'b0, mem_req}, 32'h1);
                    chk("mem_addr_stable", mem_addr, prev_addr);
                end
                prev_wait = mem_req && !mem_ack;
                prev_addr = mem_addr;
                if (inst_valid && inst_ready && !redirect_valid && !fetch_fault) begin
                    accepts++;
                    if (expq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL accept_unexpected: got pc %h expected no instruction", inst_pc);
                    end else begin
                        e = expq.pop_front();
                        chk("accept_pc", inst_pc, e);
                        chk("accept_insn", instruction, mem_word(e));
                        chk("accept_pc_plus4", inst_pc_plus4, e + 32'd4);
                        expq.push_back(e + 32'd4);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          n;
        int          r;
        logic [31:0] t;
        expq.push_back(RST_PC);

        // Reset state
        @(negedge clk); @(negedge clk); #3;
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_instruction", instruction, NOP);
        chk("rst_inst_pc", inst_pc, RST_PC);
        chk("rst_inst_pc_plus4", inst_pc_plus4, RST_PC + 32'd4);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'h0);

        // Zero-latency first fetch
        @(negedge clk); reset = 1'b0; #3;
        chk("first_mem_req", {31'b0, mem_req}, 32'h1);
        chk("first_mem_addr", mem_addr, 32'h1000);
        @(negedge clk); inst_ready = 1'b1; lat_force = 3; #3;
        chk("first_valid", {31'b0, inst_valid}, 32'h1);
        chk("first_insn", instruction, 32'h0050_0093);
        chk("first_pc", inst_pc, 32'h1000);
        chk("first_pc_plus4", inst_pc_plus4, 32'h1004);
        @(negedge clk); inst_ready = 1'b0; #3;
        chk("second_mem_addr", mem_addr, 32'h1004);

        // Ack delayed 3 cycles, decode stalls 4 cycles
        n = 0;
        while (!inst_valid && n < 20) begin
            chk("slow_addr_hold", mem_addr, 32'h1004);
            n++;
            @(negedge clk); #3;
        end
        chk("slow_fetch_cycles", n, 4);
        repeat (4) begin
            chk("stall_valid", {31'b0, inst_valid}, 32'h1);
            chk("stall_pc", inst_pc, 32'h1004);
            chk("stall_insn", instruction, mem_word(32'h1004));
            @(negedge clk); #3;
        end
        @(negedge clk); inst_ready = 1'b1; #3;

        // Redirect while fetch at 0x1008 is unacked -> drain
        @(negedge clk); inst_ready = 1'b0; do_redirect(32'h2000); #3;
        chk("pre_drain_addr", mem_addr, 32'h1008);
        @(negedge clk); redirect_valid = 1'b0; #3;
        n = 0;
        while (mem_addr != 32'h2000 && n < 20) begin
            chk("drain_addr", mem_addr, 32'h1008);
            chk("drain_no_valid", {31'b0, inst_valid}, 32'h0);
            n++;
            @(negedge clk); #3;
        end
        chk("drain_cycles", n, 3);
        chk("post_drain_req", {31'b0, mem_req}, 32'h1);
        lat_force = 0;

        // Redirect in HOLD with inst_ready high -> dropped
        wait_valid("wait_2000", 20);
        @(negedge clk); inst_ready = 1'b1; do_redirect(32'h3000); #3;
        chk("hold_pc_2000", inst_pc, 32'h2000);
        @(negedge clk); inst_ready = 1'b0; redirect_valid = 1'b0; #3;
        chk("hold_redirect_drop", {31'b0, inst_valid}, 32'h0);
        chk("hold_redirect_addr", mem_addr, 32'h3000);
        wait_valid("wait_3000", 20);
        accept_one();

        // PC wrap
        @(negedge clk); do_redirect(32'hFFFF_FFFC);
        @(negedge clk); redirect_valid = 1'b0; #3;
        wait_valid("wait_wrap", 20);
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", inst_pc_plus4, 32'h0);
        accept_one();
        #3;
        chk("wrap_mem_addr", mem_addr, 32'h0);

        // Misaligned redirect target
        @(negedge clk); do_redirect(32'h2002);
        @(negedge clk); redirect_valid = 1'b0; #3;
        wait_valid("wait_misalign", 20);
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk("fault_flag", {31'b0, fetch_fault}, 32'h1);
        chk("fault_insn", instruction, NOP);
        chk("fault_pc", inst_pc, 32'h2002);
        chk("fault_no_req", {31'b0, mem_req}, 32'h0);
        @(negedge clk); inst_ready = 1'b1; #3;
        @(negedge clk); #3;
        chk("fault_sticky", {31'b0, fetch_fault}, 32'h1);
        chk("fault_sticky_valid", {31'b0, inst_valid}, 32'h1);
        chk("fault_sticky_no_req", {31'b0, mem_req}, 32'h0);
        @(negedge clk); inst_ready = 1'b0; do_redirect(32'h2004);
        @(negedge clk); redirect_valid = 1'b0; #3;
        chk("fault_cleared", {31'b0, fetch_fault}, 32'h0);
        chk("fault_refetch_addr", mem_addr, 32'h2004);
        chk("fault_refetch_req", {31'b0, mem_req}, 32'h1);
`else
        chk("nofault_flag", {31'b0, fetch_fault}, 32'h0);
        chk("nofault_pc", inst_pc, 32'h2000);
        chk("nofault_insn", instruction, mem_word(32'h2000));
        accept_one();
`endif

        // Randomized traffic
        lat_force = -1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset = 1'b0;
            redirect_valid = 1'b0;
            inst_ready = ($urandom_range(0, 1) == 1);
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                reset = 1'b1;
                expq.delete();
                expq.push_back(RST_PC);
            end else if (r < 6) begin
                t = (r == 5) ? 32'hFFFF_FFF8 : 32'h0000_4000 + 32'($urandom_range(0, 63)) * 32'd4;
`ifndef IFETCH_MISALIGN_CHECK_EN
                t = t | 32'($urandom_range(0, 3));
`endif
                do_redirect(t);
            end
        end
        @(negedge clk);
        reset = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        repeat (5) @(negedge clk);
        #3;
        chk("random_accepts_seen", {31'b0, accepts > 100}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
